// File: rtl/db15_joy_responder.sv
// Slave end of the DB15 serial joystick link: a 74HC165-style load/shift chain that
// answers JOY_LOAD / JOY_CLK from the master. Optional protocol checker: DB15_RESP_CHK_EN.
module db15_joy_responder #(
  parameter int PLAYER_BITS = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   Reset_n,
  input  logic [PLAYER_BITS-1:0] joystick1,
  input  logic [PLAYER_BITS-1:0] joystick2,
  input  logic                   JOY_CLK,
  input  logic                   JOY_LOAD,
  output logic                   JOY_DATA,
  output logic                   frame_done,
  output logic                   overrun,
  output logic [7:0]             err_count
);

  localparam int FRAME_BITS = 2 * PLAYER_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_ld_sync;
  logic                   r_clk_prev;
  logic                   w_clk_rise;
  logic                   w_ld_sync;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    w_shift;
  logic                    w_last_shift;
  logic [FRAME_BITS-1:0]   r_sr;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic                    r_frame_done;
  logic                    r_overrun;

  // NOTE: synchronizers reset to the pin idle level (high) so a pin already high
  // when reset releases does not look like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_clk_sync <= '1;
      r_ld_sync  <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous value of
      // its neighbour, which is what makes this a shift chain rather than a wire.
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], JOY_CLK};
      r_ld_sync  <= {r_ld_sync[SYNC_STAGES-2:0], JOY_LOAD};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_clk_rise = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
  assign w_ld_sync  = r_ld_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!Reset_n) r_state <= ST_DONE;
    else          r_state <= w_next_state;
  end

  // Load dominates everything; a clock edge in the LOAD->SHIFT clk is dropped.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_next_state = r_state;
    w_shift      = 1'b0;
    w_last_shift = 1'b0;
    if (!w_ld_sync) begin
      w_next_state = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD:  w_next_state = ST_SHIFT;
        ST_SHIFT: begin
          if (w_clk_rise) begin
            w_shift = 1'b1;
            if (r_bit_cnt == LAST_CNT) begin
              w_last_shift = 1'b1;
              w_next_state = ST_DONE;
            end
          end
        end
        ST_DONE:  w_shift = w_clk_rise;
        default:  w_next_state = ST_DONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_sr         <= '1;
      r_bit_cnt    <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= w_last_shift;
      if (!w_ld_sync) begin
        r_sr      <= ~{joystick2, joystick1};
        r_bit_cnt <= '0;
        r_overrun <= 1'b0;
      end else if (w_shift) begin
        r_sr <= {1'b1, r_sr[FRAME_BITS-1:1]};
        if (r_state == ST_DONE) begin
          r_bit_cnt <= FULL_CNT;
          r_overrun <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  assign JOY_DATA   = r_sr[0];
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

`ifdef DB15_RESP_CHK_EN
  logic       w_err;
  logic [7:0] r_err_count;

  // Short frame and clock-during-load share one increment when they coincide.
  assign w_err = !w_ld_sync &&
                 (w_clk_rise || ((r_bit_cnt != '0) && (r_bit_cnt < FULL_CNT)));

  always_ff @(posedge clk) begin
    if (!Reset_n)                          r_err_count <= '0;
    else if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
  end

  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif

endmodule
